// File: rtl/uart_pkg.sv
// uart_pkg -- shared types, defaults and helpers for the UART blocks.
//
// Contents:
//   tx_state_t           transmit FSM state encoding
//   DEFAULT_CLKS_PER_BIT 50 MHz system clock / 115200 baud
//   even_parity()        XOR of a data byte; unused upper bits must be zero.
//                        Shared with the receive-side controller.
//
// Optional feature macro used by the UART blocks: UART_PARITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 434;

  // Even parity bit: 1 when the byte holds an odd number of ones.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if -- byte handshake between a producer and the UART
// transmit controller.
//
// Signals:
//   tx_data   byte to send, valid while tx_valid is high
//   tx_valid  producer offers a byte
//   tx_ready  controller accepts a byte on an edge with tx_valid high
//
// Modports: master (byte producer), slave (transmit controller).
interface uart_tx_ctrl_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/baud_tick_gen.sv
// baud_tick_gen -- bit-period counter for the UART transmitter.
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-low reset
//   run    counter runs while high, held at zero while low
//   tick   high in the terminal-count cycle (count == CLKS_PER_BIT-1)
//
// Parameter CLKS_PER_BIT (>= 2): clock cycles per serial bit.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count_reg;

  assign tick = run && (count_reg == TERMINAL);

  // Wrapping on tick makes every bit exactly CLKS_PER_BIT cycles long;
  // clearing while idle makes the first bit start from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (!run || tick) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl -- UART transmit controller.
//
// Takes one byte per valid/ready handshake and shifts it out as
// start bit, DATA_BITS data bits LSB-first, optional even parity bit,
// stop bit.
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-low reset
//   bus    uart_tx_ctrl_if.slave byte handshake (tx_data/tx_valid/tx_ready)
//   tx     registered serial output, idles high
//   busy   high while a frame is in progress
//   done   one-cycle pulse in the last cycle of the stop bit
//
// Parameters: CLKS_PER_BIT (>= 2), DATA_BITS (5..8).
// Optional feature: define UART_PARITY_EN to insert an even parity bit.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_ctrl_if.slave  bus,
  output logic           tx,
  output logic           busy,
  output logic           done
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  tx_state_t            state_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic [IDX_W-1:0]     bit_idx_reg;
  logic                 tx_reg;
  logic                 bit_tick;
`ifdef UART_PARITY_EN
  logic                 parity_reg;
`endif

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .reset(reset),
    .run  (busy),
    .tick (bit_tick)
  );

  assign busy         = (state_reg != IDLE);
  assign bus.tx_ready = (state_reg == IDLE);
  assign done         = (state_reg == STOP) && bit_tick;
  assign tx           = tx_reg;

  // tx_reg is loaded with the level of the bit being entered, so the line
  // changes on the same edge as the state and has no path from the inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_idx_reg <= '0;
      tx_reg      <= 1'b1;
`ifdef UART_PARITY_EN
      parity_reg  <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          tx_reg <= 1'b1;
          if (bus.tx_valid) begin
            shift_reg   <= bus.tx_data;
            bit_idx_reg <= '0;
            tx_reg      <= 1'b0;
            state_reg   <= START;
`ifdef UART_PARITY_EN
            parity_reg  <= even_parity(8'(bus.tx_data));
`endif
          end
        end

        START: begin
          if (bit_tick) begin
            state_reg   <= DATA;
            bit_idx_reg <= '0;
            tx_reg      <= shift_reg[0];
          end
        end

        DATA: begin
          if (bit_tick) begin
            shift_reg <= shift_reg >> 1;
            if (bit_idx_reg == LAST_IDX) begin
              bit_idx_reg <= '0;
`ifdef UART_PARITY_EN
              state_reg   <= PARITY;
              tx_reg      <= parity_reg;
`else
              state_reg   <= STOP;
              tx_reg      <= 1'b1;
`endif
            end else begin
              bit_idx_reg <= bit_idx_reg + IDX_W'(1);
              // Next data bit is the one about to land in shift_reg[0].
              tx_reg      <= shift_reg[1];
            end
          end
        end

`ifdef UART_PARITY_EN
        PARITY: begin
          if (bit_tick) begin
            state_reg <= STOP;
            tx_reg    <= 1'b1;
          end
        end
`endif

        STOP: begin
          if (bit_tick) begin
            state_reg <= IDLE;
            tx_reg    <= 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
          tx_reg    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl -- directed bench for uart_tx_ctrl with a byte scoreboard.
// Build with UART_PARITY_EN defined to exercise the parity frame format.
module tb_uart_tx_ctrl;

  localparam int CPB = 4;
  localparam int DB  = 8;
`ifdef UART_PARITY_EN
  localparam int NBITS = DB + 3;
`else
  localparam int NBITS = DB + 2;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic tx;
  logic busy;
  logic done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] sb_q[$];

  uart_tx_ctrl_if #(.DATA_BITS(DB)) bus ();

  uart_tx_ctrl #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .tx   (tx),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_tx"}, tx, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_ready"}, bus.tx_ready, 1'b1);
    chk({tag, "_done"}, done, 1'b0);
  endtask

  // Offer a byte at a negedge, push it to the scoreboard, and check that
  // the start bit appears right after the accepting edge.
  task automatic send(input logic [7:0] d, input bit hold);
    chk("pre_send_tx", tx, 1'b1);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    sb_q.push_back(d);
    step();
    if (!hold) bus.tx_valid = 1'b0;
    chk("accept_latency_tx", tx, 1'b0);
    chk("accept_ready_low", bus.tx_ready, 1'b0);
  endtask

  // Wait for a start bit, pop the expected byte and check every cycle of
  // the frame. With glitch set, tx_valid is pulsed mid-frame and in the
  // last stop cycle with a byte that must never be sent.
  task automatic expect_frame(input bit glitch, output int start);
    logic [7:0] d;
    logic       exp_bits[NBITS];
    logic       par;
    int         w;
    int         k;
    start = -1;
    w = 0;
    while (tx !== 1'b0 && w < 20) begin
      step();
      w++;
    end
    chk("frame_start_seen", tx, 1'b0);
    if (tx !== 1'b0) return;
    start = cyc;
    chk("sb_nonempty", (sb_q.size() > 0), 1'b1);
    if (sb_q.size() == 0) return;
    d = sb_q.pop_front();
    par = 1'b0;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < DB; i++) begin
      exp_bits[1+i] = d[i];
      par = par ^ d[i];
    end
`ifdef UART_PARITY_EN
    exp_bits[DB+1] = par;
`endif
    exp_bits[NBITS-1] = 1'b1;
    for (int b = 0; b < NBITS; b++) begin
      for (int c = 0; c < CPB; c++) begin
        k = b * CPB + c;
        chk($sformatf("tx_b%0d_c%0d", b, c), tx, exp_bits[b]);
        chk($sformatf("busy_k%0d", k), busy, 1'b1);
        chk($sformatf("ready_k%0d", k), bus.tx_ready, 1'b0);
        chk($sformatf("done_k%0d", k), done, (b == NBITS-1 && c == CPB-1));
        if (glitch) begin
          if (k == 10 || k == NBITS*CPB-1) begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = 8'hC3;
          end else begin
            bus.tx_valid = 1'b0;
          end
        end
        step();
      end
    end
    if (glitch) bus.tx_valid = 1'b0;
    chk("end_ready", bus.tx_ready, 1'b1);
    chk("end_busy", busy, 1'b0);
    chk("end_tx", tx, 1'b1);
    chk("end_done", done, 1'b0);
    $display("frame data=%02h start_cycle=%0d parity=%0b", d, start, par);
  endtask

  initial begin
    int s;
    int s1;
    int s2;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;

    // Scenario 1: reset values, then a quiet idle line.
    #1 reset = 1'b0;
    #1 chk_idle("in_reset");
    repeat (3) step();
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk_idle($sformatf("idle%0d", i));
      step();
    end
    $display("idle check done cycles=20");

    // Scenario 2: single frame of 0xA5.
    send(8'hA5, 1'b0);
    expect_frame(1'b0, s);

    // Scenario 3: tx_valid held high for two frames; data changes mid-frame.
    send(8'h00, 1'b1);
    bus.tx_data = 8'hFF;
    sb_q.push_back(8'hFF);
    expect_frame(1'b0, s1);
    step();
    bus.tx_valid = 1'b0;
    expect_frame(1'b0, s2);
    chk("frame_spacing", s2 - s1, NBITS*CPB + 1);
    $display("back-to-back spacing=%0d", s2 - s1);

    // Scenario 5: tx_valid pulses while busy must be ignored.
    send(8'h55, 1'b0);
    expect_frame(1'b1, s);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("no_extra_frame%0d", i), {busy, tx}, 2'b01);
      step();
    end

    // Scenario 4: asynchronous reset in cycle 15 of a 0x3C frame.
    send(8'h3C, 1'b0);
    repeat (14) step();
    chk("pre_abort_busy", busy, 1'b1);
    #2 reset = 1'b0;
    #1 chk_idle("async_abort");
    void'(sb_q.pop_back());
    $display("frame data=3c aborted by reset");
    step();
    step();
    reset = 1'b1;
    send(8'h81, 1'b0);
    expect_frame(1'b0, s);

    // Scenario 6: parity frames (plain frames when parity is disabled).
    send(8'hA5, 1'b0);
    expect_frame(1'b0, s);
    send(8'h07, 1'b0);
    expect_frame(1'b0, s);

    chk("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Transmit-side controller for the UART. It accepts one byte per valid/ready handshake and sequences it onto the serial line as a frame: start bit, 8 data bits LSB-first, optional parity bit, stop bit. Bit timing comes from an internal baud divider. The block sits between the byte-producing logic and the tx pin, and replaces ad-hoc chains of single flip-flops with one sequenced shift register.

Parameters:
CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); legal range is 2 or more.
DATA_BITS, 8, number of data bits per frame; legal range is 5 to 8.

Ports:
clk  input  1  system clock; all state updates on the posedge.
reset  input  1  asynchronous, active-low reset; the block is held in reset while reset==0.
tx_data  input  DATA_BITS  byte to send; sampled only on an accepted handshake.
tx_valid  input  1  producer has a byte on tx_data.
tx_ready  output  1  controller can accept a byte; high only in IDLE.
tx  output  1  serial line; idles high.
busy  output  1  high while a frame is in progress (any state other than IDLE).
done  output  1  single-cycle pulse in the final cycle of the stop bit.

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, tx=1, tx_ready=1, busy=0, done=0, baud counter=0, bit index=0, shift register=0. Any frame in flight is aborted and its data discarded. The line returns high immediately, without waiting for a clock edge.
- States: IDLE, START, DATA, PARITY (present only with the optional feature), STOP.
- Handshake: a byte is accepted on a posedge where tx_valid && tx_ready. On that edge, tx_data is latched into the shift register and the state becomes START. tx_valid and tx_data are ignored outside IDLE. A producer that holds tx_valid high gets one frame per IDLE visit.
- Latency: tx goes low in the cycle after the accepting edge.
- Baud counter:
  - Width is $clog2(CLKS_PER_BIT).
  - It counts 0 to CLKS_PER_BIT-1 in every non-IDLE state.
  - A bit ends at terminal count; the counter then wraps to 0 and the FSM advances.
  - Each bit is held for exactly CLKS_PER_BIT cycles.
- START: tx=0 for one bit time, then go to DATA with bit index=0.
- DATA:
  - tx = shift_reg[0].
  - At each bit end, shift right and increment the bit index.
  - After bit index DATA_BITS-1 completes, go to PARITY if that feature is enabled, otherwise to STOP.
- STOP:
  - tx=1 for one bit time.
  - done=1 during the last cycle of STOP (the terminal-count cycle).
  - The next state is IDLE.
- Frame length without parity: (DATA_BITS+2)*CLKS_PER_BIT cycles, from the first START cycle to the last STOP cycle.
- Minimum spacing: at least one IDLE cycle between frames, so back-to-back frame starts are (DATA_BITS+2)*CLKS_PER_BIT+1 cycles apart.
- Output timing: tx is registered, with no combinational path from the inputs. tx_ready and busy decode the state.
- Reset deasserting mid-line: the FSM starts in IDLE and accepts a handshake on the first posedge after release.

Optional Feature:
UART_PARITY_EN
- Defined:
  - The PARITY state is inserted after DATA for one bit time.
  - tx = XOR of the latched data bits (even parity), computed at acceptance and stored in a register.
  - Frame length becomes (DATA_BITS+3)*CLKS_PER_BIT.
- Undefined: no PARITY state and no parity register; the frame is DATA_BITS+2 bits.

Decomposition:
- Package uart_pkg:
  - typedef enum logic [2:0] tx_state_t {IDLE, START, DATA, PARITY, STOP};
  - localparam DEFAULT_CLKS_PER_BIT = 434;
  - function even_parity(). This is shared with the future uart_rx_ctrl.
- Sub-module baud_tick_gen(clk, reset, run, tick), parameterised by CLKS_PER_BIT:
  - Holds the counter.
  - tick is high on terminal count.
  - The counter clears while run==0.
  - The controller drives run = busy.

Test Plan:
All scenarios use CLKS_PER_BIT=4 and DATA_BITS=8.
1. Reset, then hold tx_valid=0 for 20 cycles -> tx=1, tx_ready=1, busy=0, done=0 throughout.
2. Send 0xA5 -> from the cycle after acceptance, tx holds each level for 4 cycles in the order 0,1,0,1,0,0,1,0,1,1. done pulses at cycle 40. tx_ready returns high at cycle 41.
3. Hold tx_valid=1 continuously, with tx_data=0x00 then 0xFF -> two complete frames, starts 41 cycles apart. tx_data changes during frame 1 do not alter its bits.
4. Pull reset low at cycle 15 of a 0x3C frame -> tx=1 and busy=0 with no clock edge needed. After release, a new 0x81 frame transmits correctly.
5. Pulse tx_valid while busy -> ignored, and no extra frame follows.
6. With UART_PARITY_EN defined:
   - 0xA5 -> a parity bit of 0 is inserted before the stop bit, and done pulses at cycle 44.
   - 0x07 -> parity bit is 1.
